// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - MMIO UART controller offsets, status bits, access kinds and FIFO pointer sizing
package mmio_pkg;

    localparam logic [7:0] MMIO_STATUS = 8'h00;
    localparam logic [7:0] MMIO_RX     = 8'h04;
    localparam logic [7:0] MMIO_TX     = 8'h08;
    localparam logic [7:0] MMIO_CYC    = 8'h10;
    localparam logic [7:0] MMIO_INST   = 8'h14;
    localparam logic [7:0] MMIO_CRST   = 8'h18;

    localparam int ST_TX_NFULL  = 0;
    localparam int ST_RX_NEMPTY = 1;
    localparam int ST_TX_OVF    = 2;

    typedef enum logic [2:0] {
        ACC_NONE,
        ACC_UNMAPPED,
        ACC_STATUS,
        ACC_RX_POP,
        ACC_TX_PUSH,
        ACC_CYC,
        ACC_INST,
        ACC_CRST
    } mmio_acc_e;

    // One extra pointer bit tells full from empty when the index bits match.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mmio_uart_ctrl_if.sv
// rtl/mmio_uart_ctrl_if.sv - CPU MMIO request/response and UART handshake bundle
interface mmio_uart_ctrl_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [7:0]  req_wdata;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;
    logic        inst_retired;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  rd_data, rd_valid,
        input  uart_tx_data, uart_tx_valid,
        output uart_tx_ready,
        output uart_rx_data, uart_rx_valid,
        input  uart_rx_ready,
        output inst_retired
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output rd_data, rd_valid,
        output uart_tx_data, uart_tx_valid,
        input  uart_tx_ready,
        input  uart_rx_data, uart_rx_valid,
        output uart_rx_ready,
        input  inst_retired
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; push on full and pop on empty are ignored
module sync_fifo
    import mmio_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[PW-1] != r_rptr[PW-1]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_head    = r_mem[r_rptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// rtl/mmio_uart_ctrl.sv - MMIO UART controller top; MMIO_COUNTERS_EN adds cycle/instret counters
module mmio_uart_ctrl
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    mmio_uart_ctrl_if.slave bus
);
    mmio_acc_e   w_acc;
    logic        w_hit;
    logic        w_load;
    logic [7:0]  w_off;
    logic        w_tx_full;
    logic        w_tx_empty;
    logic        w_rx_full;
    logic        w_rx_empty;
    logic [7:0]  w_tx_head;
    logic [7:0]  w_rx_head;
    logic        w_tx_push;
    logic        w_tx_pop;
    logic        w_rx_push;
    logic        w_rx_pop;
    logic        w_ovf_set;
    logic        w_crst;
    logic [31:0] w_load_data;
    logic [31:0] w_cyc;
    logic [31:0] w_inst;
    logic        r_ovf;
    logic        r_rx_en;
    logic        r_rd_valid;
    logic [31:0] r_rd_data;

    assign w_hit  = bus.req_valid && (bus.req_addr[31:8] == BASE_ADDR[31:8]);
    assign w_off  = bus.req_addr[7:0];
    assign w_load = w_hit && !bus.req_we;

    always_comb begin
        w_acc = ACC_NONE;
        if (w_hit) begin
            w_acc = ACC_UNMAPPED;
            if (bus.req_we) begin
                if (w_off == MMIO_TX)        w_acc = ACC_TX_PUSH;
                else if (w_off == MMIO_CRST) w_acc = ACC_CRST;
            end else begin
                case (w_off)
                    MMIO_STATUS: w_acc = ACC_STATUS;
                    MMIO_RX:     w_acc = ACC_RX_POP;
                    MMIO_CYC:    w_acc = ACC_CYC;
                    MMIO_INST:   w_acc = ACC_INST;
                    default:     w_acc = ACC_UNMAPPED;
                endcase
            end
        end
    end

    // Full/empty come straight from the FIFO pointer registers, so every
    // accept/drop decision below sees start-of-cycle state.
    assign w_tx_push = (w_acc == ACC_TX_PUSH);
    assign w_ovf_set = w_tx_push && w_tx_full;
    assign w_tx_pop  = !w_tx_empty && bus.uart_tx_ready;
    assign w_rx_pop  = (w_acc == ACC_RX_POP);
    assign w_rx_push = bus.uart_rx_valid && bus.uart_rx_ready;
    assign w_crst    = (w_acc == ACC_CRST);

    assign bus.uart_tx_valid = !w_tx_empty;
    assign bus.uart_tx_data  = w_tx_head;
    assign bus.uart_rx_ready = r_rx_en && !w_rx_full;
    assign bus.rd_data       = r_rd_data;
    assign bus.rd_valid      = r_rd_valid;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tx_push),
        .i_wdata (bus.req_wdata),
        .i_pop   (w_tx_pop),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_head  (w_tx_head)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_push),
        .i_wdata (bus.uart_rx_data),
        .i_pop   (w_rx_pop),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_head  (w_rx_head)
    );

`ifdef MMIO_COUNTERS_EN
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_inst_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cyc_cnt  <= '0;
            r_inst_cnt <= '0;
        end else if (w_crst) begin
            r_cyc_cnt  <= '0;
            r_inst_cnt <= '0;
        end else begin
            r_cyc_cnt  <= r_cyc_cnt + 32'd1;
            r_inst_cnt <= r_inst_cnt + {31'd0, bus.inst_retired};
        end
    end

    assign w_cyc  = r_cyc_cnt;
    assign w_inst = r_inst_cnt;
`else
    logic w_unused_cnt;
    assign w_unused_cnt = bus.inst_retired ^ w_crst;
    assign w_cyc        = '0;
    assign w_inst       = '0;
`endif

    always_comb begin
        w_load_data = 32'd0;
        case (w_acc)
            ACC_STATUS: begin
                w_load_data[ST_TX_NFULL]  = !w_tx_full;
                w_load_data[ST_RX_NEMPTY] = !w_rx_empty;
                w_load_data[ST_TX_OVF]    = r_ovf || w_ovf_set;
            end
            ACC_RX_POP: if (!w_rx_empty) w_load_data = {24'd0, w_rx_head};
            ACC_CYC:    w_load_data = w_cyc;
            ACC_INST:   w_load_data = w_inst;
            default:    w_load_data = 32'd0;
        endcase
    end

    // r_rx_en keeps rx_ready low through reset and raises it at the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_en    <= 1'b0;
            r_ovf      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 32'd0;
        end else begin
            r_rx_en    <= 1'b1;
            r_rd_valid <= w_load;
            if (w_load) r_rd_data <= w_load_data;
            if (w_ovf_set)                 r_ovf <= 1'b1;
            else if (w_acc == ACC_STATUS)  r_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// tb/tb_mmio_uart_ctrl.sv - randomized and directed bench for mmio_uart_ctrl against a queue model
module tb_mmio_uart_ctrl;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h8000_0000;
`ifdef MMIO_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    mmio_uart_ctrl_if bus();

    mmio_uart_ctrl #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  m_tx[$];
    logic [7:0]  m_rx[$];
    logic [7:0]  rx_src[$];
    logic [7:0]  tx_log[$];
    bit          m_ovf;
    bit          m_rx_en;
    logic [31:0] m_cyc;
    logic [31:0] m_inst;
    logic [31:0] last_rd;
    bit          g_tx_rdy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_tx.delete();
        m_rx.delete();
        rx_src.delete();
        m_ovf   = 1'b0;
        m_rx_en = 1'b0;
        m_cyc   = 32'd0;
        m_inst  = 32'd0;
    endtask

    // One clock: drive inputs at the falling edge, predict from pre-edge model state, check after the edge.
    task automatic cycle(input bit valid, input bit we, input logic [31:0] addr,
                         input logic [7:0] wdata, input bit inst);
        bit          hit, ld, tx_full, rx_empty, tx_pop, rx_push, rx_rdy;
        logic [7:0]  off;
        logic [31:0] exp;
        bus.req_valid     = valid;
        bus.req_we        = we;
        bus.req_addr      = addr;
        bus.req_wdata     = wdata;
        bus.uart_tx_ready = g_tx_rdy;
        bus.inst_retired  = inst;
        bus.uart_rx_valid = (rx_src.size() != 0);
        bus.uart_rx_data  = (rx_src.size() != 0) ? rx_src[0] : 8'h00;
        #1;
        tx_full  = (m_tx.size() == DEPTH);
        rx_empty = (m_rx.size() == 0);
        rx_rdy   = m_rx_en && (m_rx.size() < DEPTH);
        chk("tx_valid", 32'(bus.uart_tx_valid), 32'(m_tx.size() != 0));
        if (m_tx.size() != 0) chk("tx_data", 32'(bus.uart_tx_data), 32'(m_tx[0]));
        chk("rx_ready", 32'(bus.uart_rx_ready), 32'(rx_rdy));

        hit = valid && (addr[31:8] == BASE[31:8]);
        off = addr[7:0];
        ld  = hit && !we;
        exp = 32'd0;
        if (ld) begin
            case (off)
                8'h00:   exp = {29'd0, m_ovf, !rx_empty, !tx_full};
                8'h04:   exp = rx_empty ? 32'd0 : {24'd0, m_rx[0]};
                8'h10:   exp = CNT_EN ? m_cyc : 32'd0;
                8'h14:   exp = CNT_EN ? m_inst : 32'd0;
                default: exp = 32'd0;
            endcase
        end

        tx_pop  = (m_tx.size() != 0) && g_tx_rdy;
        rx_push = (rx_src.size() != 0) && rx_rdy;
        if (tx_pop) begin
            tx_log.push_back(m_tx[0]);
            void'(m_tx.pop_front());
        end
        if (ld && off == 8'h00) m_ovf = 1'b0;
        if (hit && we && off == 8'h08) begin
            if (tx_full) m_ovf = 1'b1;
            else         m_tx.push_back(wdata);
        end
        if (ld && off == 8'h04 && !rx_empty) void'(m_rx.pop_front());
        if (rx_push) begin
            m_rx.push_back(rx_src[0]);
            void'(rx_src.pop_front());
        end
        if (hit && we && off == 8'h18) begin
            m_cyc  = 32'd0;
            m_inst = 32'd0;
        end else begin
            m_cyc  = m_cyc + 32'd1;
            m_inst = m_inst + 32'(inst);
        end

        @(posedge clk);
        @(negedge clk);
        m_rx_en = 1'b1;
        chk("rd_valid", 32'(bus.rd_valid), 32'(ld));
        if (ld) chk($sformatf("rd_data@%h", off), bus.rd_data, exp);
        last_rd = bus.rd_data;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 8'd0, 1'b0);
    endtask

    task automatic load(input logic [31:0] addr);
        cycle(1'b1, 1'b0, addr, 8'd0, 1'b0);
    endtask

    task automatic store(input logic [31:0] addr, input logic [7:0] d);
        cycle(1'b1, 1'b1, addr, d, 1'b0);
    endtask

    initial begin
        rst               = 1'b0;
        bus.req_valid     = 1'b0;
        bus.req_we        = 1'b0;
        bus.req_addr      = 32'd0;
        bus.req_wdata     = 8'd0;
        bus.uart_tx_ready = 1'b0;
        bus.uart_rx_valid = 1'b0;
        bus.uart_rx_data  = 8'd0;
        bus.inst_retired  = 1'b0;
        g_tx_rdy          = 1'b0;
        last_rd           = 32'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_rd_data", bus.rd_data, 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_tx_valid", 32'(bus.uart_tx_valid), 32'd0);
        chk("rst_rx_ready", 32'(bus.uart_rx_ready), 32'd0);
        rst = 1'b1;

        load(BASE);
        chk("status_after_reset", last_rd, 32'h1);
        idle(1);

        // TX overflow: nine stores into an eight-deep FIFO with the transmitter stalled.
        g_tx_rdy = 1'b0;
        for (int i = 0; i < 9; i++) store(BASE + 32'h08, 8'(8'h41 + i));
        load(BASE);
        chk("status_tx_full_ovf", last_rd, 32'h4);
        tx_log.delete();
        g_tx_rdy = 1'b1;
        idle(12);
        chk("tx_emitted_count", 32'(tx_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < tx_log.size(); i++)
            chk("tx_emitted_byte", 32'(tx_log[i]), 32'h41 + 32'(i));
        load(BASE);
        chk("status_ovf_cleared", last_rd, 32'h1);

        // RX: two bytes in, three loads out.
        rx_src.push_back(8'h55);
        rx_src.push_back(8'hAA);
        idle(3);
        load(BASE);
        chk("status_rx_nempty", last_rd, 32'h3);
        load(BASE + 32'h04);
        chk("rx_first", last_rd, 32'h55);
        load(BASE + 32'h04);
        chk("rx_second", last_rd, 32'hAA);
        load(BASE + 32'h04);
        chk("rx_empty_zero", last_rd, 32'h0);

        // RX backpressure: nine bytes offered, the ninth must wait for one pop.
        for (int i = 0; i < 9; i++) rx_src.push_back(8'(8'h10 + i));
        idle(12);
        chk("rx_full_ready_low", 32'(bus.uart_rx_ready), 32'd0);
        chk("rx_src_stalled", 32'(rx_src.size()), 32'd1);
        load(BASE + 32'h04);
        chk("rx_full_head", last_rd, 32'h10);
        idle(1);
        chk("rx_ninth_taken", 32'(rx_src.size()), 32'd0);
        for (int i = 1; i < 9; i++) begin
            load(BASE + 32'h04);
            chk("rx_drain", last_rd, 32'h10 + 32'(i));
        end

        // Counters.
        store(BASE + 32'h18, 8'h00);
        idle(10);
        load(BASE + 32'h10);
        chk("cyc_after_crst", last_rd, CNT_EN ? 32'd10 : 32'd0);
        store(BASE + 32'h18, 8'h5A);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'd0, 8'd0, 1'b1);
        load(BASE + 32'h14);
        chk("inst_five", last_rd, CNT_EN ? 32'd5 : 32'd0);
`ifdef MMIO_COUNTERS_EN
        force dut.r_inst_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_inst_cnt;
        m_inst = 32'hFFFF_FFFF;
        cycle(1'b0, 1'b0, 32'd0, 8'd0, 1'b1);
        load(BASE + 32'h14);
        chk("inst_wrap", last_rd, 32'd0);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            int r;
            g_tx_rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0 && rx_src.size() < 4) rx_src.push_back(8'($urandom));
            r = int'($urandom_range(0, 11));
            case (r)
                0, 1, 2: store(BASE + 32'h08, 8'($urandom));
                3:       load(BASE);
                4, 5:    load(BASE + 32'h04);
                6:       load(BASE + 32'h10);
                7:       load(BASE + 32'h14);
                8:       cycle(1'b1, $urandom_range(0, 1) == 1, BASE | 32'($urandom_range(0, 255)), 8'($urandom), 1'b0);
                9:       cycle(1'b1, $urandom_range(0, 1) == 1, $urandom, 8'($urandom), 1'b0);
                10:      if ($urandom_range(0, 7) == 0) store(BASE + 32'h18, 8'($urandom));
                         else idle(1);
                default: cycle(1'b0, 1'b0, 32'd0, 8'd0, $urandom_range(0, 1) == 1);
            endcase
        end

        // Asynchronous reset with bytes queued and a load response on the bus.
        g_tx_rdy = 1'b0;
        idle(1);
        while (m_tx.size() != 0 && tx_log.size() < 100000) begin
            g_tx_rdy = 1'b1;
            idle(1);
        end
        g_tx_rdy = 1'b0;
        for (int i = 0; i < 3; i++) store(BASE + 32'h08, 8'(8'hC0 + i));
        load(BASE);
        chk("pre_reset_tx_valid", 32'(bus.uart_tx_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_tx_valid", 32'(bus.uart_tx_valid), 32'd0);
        chk("async_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("async_rx_ready", 32'(bus.uart_rx_ready), 32'd0);
        model_reset();
        bus.req_valid     = 1'b0;
        bus.uart_rx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        load(BASE);
        chk("status_after_async", last_rd, 32'h1);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
